// File: rtl/spio_hss_multiplexer_pkt_fifo_gen_pkg.sv
// rtl/spio_hss_multiplexer_pkt_fifo_gen_pkg.sv - shared constants and types for the HSS packet dispatch FIFO
package spio_hss_multiplexer_pkt_fifo_gen_pkg;

  // Packet width of the HSS multiplexer transmit path.
  localparam int SPIO_PKT_BITS = 72;

  typedef struct packed {
    logic wr;
    logic rd;
    logic drop;
  } xfer_t;

  // Pointer width for an array of depth-1 entries; never narrower than one bit.
  function automatic int ptr_bits(input int depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/spio_hss_multiplexer_pkt_fifo_mem.sv
// rtl/spio_hss_multiplexer_pkt_fifo_mem.sv - DEPTH-1 entry packet array behind the output register
module spio_hss_multiplexer_pkt_fifo_mem
  import spio_hss_multiplexer_pkt_fifo_gen_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PKT_BITS = SPIO_PKT_BITS,
  localparam int PTR_BITS = ptr_bits(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [PTR_BITS-1:0] waddr,
  input  logic [PKT_BITS-1:0] wdata,
  input  logic [PTR_BITS-1:0] raddr,
  output logic [PKT_BITS-1:0] rdata
);

  generate
    if (DEPTH > 1) begin : g_arr
      logic [PKT_BITS-1:0] mem [DEPTH-1];

      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end

      assign rdata = mem[raddr];
    end else begin : g_none
      assign rdata = '0;
    end
  endgenerate

endmodule

// File: rtl/spio_hss_multiplexer_pkt_fifo_gen.sv
// rtl/spio_hss_multiplexer_pkt_fifo_gen.sv - parametrised packet dispatch FIFO with registered head
module spio_hss_multiplexer_pkt_fifo_gen
  import spio_hss_multiplexer_pkt_fifo_gen_pkg::*;
#(
  parameter int PKT_BITS = SPIO_PKT_BITS,
  parameter int DEPTH    = 8,
  parameter int HI_MARK  = 3 * DEPTH / 4,
  parameter int LO_MARK  = DEPTH / 4,
  localparam int OCC_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                go_frm,
  output logic                busy,
  output logic                cfcf,
  output logic                ovf,
  output logic [OCC_BITS-1:0] occ,
  input  logic [PKT_BITS-1:0] ipkt_data,
  input  logic                ipkt_vld,
  output logic [PKT_BITS-1:0] pkt_data,
  output logic                pkt_vld,
  input  logic                pkt_rdy
);

  localparam int PTR_BITS = ptr_bits(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'((DEPTH > 1) ? DEPTH - 2 : 0);

  generate
    if (!(DEPTH >= 1 && LO_MARK < HI_MARK && HI_MARK <= DEPTH)) begin : g_bad_params
      $error("spio_hss_multiplexer_pkt_fifo_gen: need DEPTH >= 1 and LO_MARK < HI_MARK <= DEPTH");
    end
  endgenerate

  xfer_t               xf;
  logic                full;
  logic                load_out;
  logic                arr_nonempty;
  logic                arr_we;
  logic                arr_re;
  logic [PTR_BITS-1:0] wrp;
  logic [PTR_BITS-1:0] rdp;
  logic [PKT_BITS-1:0] arr_rdata;
  logic [OCC_BITS-1:0] nxt_occ;

  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (occ == OCC_BITS'(DEPTH));
  assign xf.rd   = pkt_vld && pkt_rdy;
  assign xf.wr   = go_frm && ipkt_vld && (!full || xf.rd);
  assign xf.drop = go_frm && ipkt_vld && full && !xf.rd;
  assign busy    = full && ipkt_vld && !pkt_rdy;

  // The head register refills from the array first; an incoming packet only
  // bypasses straight to the head when nothing older is waiting behind it.
  assign load_out     = !pkt_vld || xf.rd;
  assign arr_nonempty = (occ > OCC_BITS'(pkt_vld));
  assign arr_re       = load_out && arr_nonempty;
  assign arr_we       = xf.wr && !(load_out && !arr_nonempty);

  always_comb begin
    nxt_occ = occ;
    case ({xf.wr, xf.rd})
      2'b10:   nxt_occ = occ + 1'b1;
      2'b01:   nxt_occ = occ - 1'b1;
      default: nxt_occ = occ;
    endcase
  end

  spio_hss_multiplexer_pkt_fifo_mem #(
    .DEPTH    (DEPTH),
    .PKT_BITS (PKT_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (arr_we),
    .waddr (wrp),
    .wdata (ipkt_data),
    .raddr (rdp),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ      <= '0;
      pkt_vld  <= 1'b0;
      pkt_data <= '0;
      wrp      <= '0;
      rdp      <= '0;
      ovf      <= 1'b0;
      cfcf     <= 1'b1;
    end else if (flush) begin
      occ     <= '0;
      pkt_vld <= 1'b0;
      wrp     <= '0;
      rdp     <= '0;
      ovf     <= 1'b0;
      cfcf    <= 1'b1;
    end else begin
      occ <= nxt_occ;
      if (xf.drop) ovf <= 1'b1;
      if (nxt_occ >= OCC_BITS'(HI_MARK))      cfcf <= 1'b0;
      else if (nxt_occ <= OCC_BITS'(LO_MARK)) cfcf <= 1'b1;
      if (arr_we) wrp <= ptr_inc(wrp);
      if (arr_re) rdp <= ptr_inc(rdp);
      if (load_out) begin
        if (arr_nonempty) begin
          pkt_data <= arr_rdata;
          pkt_vld  <= 1'b1;
        end else if (xf.wr) begin
          pkt_data <= ipkt_data;
          pkt_vld  <= 1'b1;
        end else begin
          pkt_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_fifo_gen.sv
// tb/tb_spio_hss_multiplexer_pkt_fifo_gen.sv - directed bench for the packet dispatch FIFO (depths 8, 5, 1)
module tb_spio_hss_multiplexer_pkt_fifo_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flush, go_frm, ipkt_vld, pkt_rdy;
  logic [71:0] ipkt_data;
  logic        busy, cfcf, ovf, pkt_vld;
  logic [3:0]  occ;
  logic [71:0] pkt_data;

  spio_hss_multiplexer_pkt_fifo_gen #(.PKT_BITS(72), .DEPTH(8), .HI_MARK(6), .LO_MARK(2)) u_d8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .go_frm(go_frm), .busy(busy), .cfcf(cfcf),
    .ovf(ovf), .occ(occ), .ipkt_data(ipkt_data), .ipkt_vld(ipkt_vld),
    .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy)
  );

  logic        o_sel, o_vld, o_rdy;
  logic [71:0] o_data;
  logic        d5_busy, d5_cfcf, d5_ovf, d5_vld, d1_busy, d1_cfcf, d1_ovf, d1_vld;
  logic [2:0]  d5_occ;
  logic [0:0]  d1_occ;
  logic [71:0] d5_data, d1_data;

  spio_hss_multiplexer_pkt_fifo_gen #(.PKT_BITS(72), .DEPTH(5)) u_d5 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .go_frm(1'b1), .busy(d5_busy), .cfcf(d5_cfcf),
    .ovf(d5_ovf), .occ(d5_occ), .ipkt_data(o_data), .ipkt_vld(o_vld && !o_sel),
    .pkt_data(d5_data), .pkt_vld(d5_vld), .pkt_rdy(o_rdy && !o_sel)
  );

  spio_hss_multiplexer_pkt_fifo_gen #(.PKT_BITS(72), .DEPTH(1), .HI_MARK(1), .LO_MARK(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .go_frm(1'b1), .busy(d1_busy), .cfcf(d1_cfcf),
    .ovf(d1_ovf), .occ(d1_occ), .ipkt_data(o_data), .ipkt_vld(o_vld && o_sel),
    .pkt_data(d1_data), .pkt_vld(d1_vld), .pkt_rdy(o_rdy && o_sel)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [71:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] rand72();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  task automatic wr8(input logic [71:0] d);
    ipkt_data = d;
    ipkt_vld  = 1'b1;
    go_frm    = 1'b1;
    tick();
    ipkt_vld  = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic drain_all();
    pkt_rdy = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      chk("drain_data", pkt_data, exp_q.pop_front());
      tick();
    end
    pkt_rdy = 1'b0;
    chk("drain_empty_q", exp_q.size(), 0);
    chk("drain_vld", pkt_vld, 0);
  endtask

  // From empty: fill to 8, drop one, drain three -> occ 5 with ovf set and cfcf low.
  task automatic prep5();
    pkt_rdy = 1'b0;
    for (int i = 0; i < 8; i++) wr8(rand72());
    ipkt_data = 72'hBAD; ipkt_vld = 1'b1;
    tick();
    ipkt_vld = 1'b0;
    pkt_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("prep_data", pkt_data, exp_q.pop_front());
      tick();
    end
    pkt_rdy = 1'b0;
    chk("prep_occ", occ, 5);
    chk("prep_ovf", ovf, 1);
    chk("prep_cfcf", cfcf, 0);
  endtask

  task automatic run_odd(input logic sel, input int depth);
    int sent, recv, mocc, wr_m, rd_m, got_occ;
    logic got_vld;
    logic [71:0] got_data;
    sent = 0; recv = 0; mocc = 0;
    o_sel = sel;
    for (int cyc = 0; cyc < 2000 && recv < 40; cyc++) begin
      o_vld  = (sent < 40) && ($urandom_range(0, 1) == 1);
      o_data = 72'(sent);
      o_rdy  = ($urandom_range(0, 1) == 1);
      #1;
      got_vld  = sel ? d1_vld : d5_vld;
      got_data = sel ? d1_data : d5_data;
      chk("odd_vld", got_vld, mocc > 0);
      rd_m = (mocc > 0 && o_rdy) ? 1 : 0;
      wr_m = (o_vld && (mocc < depth || rd_m == 1)) ? 1 : 0;
      if (rd_m == 1) begin
        chk("odd_data", got_data, 72'(recv));
        recv++;
      end
      sent += wr_m;
      mocc += wr_m - rd_m;
      tick();
      got_occ = sel ? int'(d1_occ) : int'(d5_occ);
      chk("odd_occ", got_occ, mocc);
    end
    o_vld = 1'b0;
    o_rdy = 1'b0;
    chk("odd_recv40", recv, 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; go_frm = 1'b0; ipkt_vld = 1'b0; pkt_rdy = 1'b0; ipkt_data = '0;
    o_sel = 1'b0; o_vld = 1'b0; o_rdy = 1'b0; o_data = '0;
    tick(); tick();
    chk("rst_vld", pkt_vld, 0);
    chk("rst_data", pkt_data, 0);
    chk("rst_occ", occ, 0);
    chk("rst_cfcf", cfcf, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Single packet, one-cycle latency through the bypass.
    wr8(72'h0123456789ABCDEF00);
    chk("single_vld", pkt_vld, 1);
    chk("single_data", pkt_data, 72'h0123456789ABCDEF00);
    chk("single_occ", occ, 1);
    chk("single_cfcf", cfcf, 1);

    // Fill: cfcf drops at the edge taking occ to 6.
    for (int i = 1; i < 8; i++) begin
      wr8({8'hA0, 64'(i)});
      chk("fill_occ", occ, i + 1);
      chk("fill_cfcf", cfcf, (i + 1) < 6);
    end

    ipkt_data = 72'hDEAD; ipkt_vld = 1'b1; go_frm = 1'b1; pkt_rdy = 1'b0;
    #1;
    chk("ovf_busy", busy, 1);
    tick();
    ipkt_vld = 1'b0;
    chk("ovf_flag", ovf, 1);
    chk("ovf_occ", occ, 8);
    chk("ovf_head_stable", pkt_data, 72'h0123456789ABCDEF00);

    // Drain with hysteresis: cfcf returns only at occ 2.
    pkt_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain8_vld", pkt_vld, 1);
      chk("drain8_data", pkt_data, exp_q.pop_front());
      tick();
      chk("drain8_occ", occ, 7 - i);
      chk("drain8_cfcf", cfcf, (7 - i) <= 2);
    end
    pkt_rdy = 1'b0;
    chk("drain8_empty", pkt_vld, 0);

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) wr8(rand72());
    chk("full_occ", occ, 8);
    for (int i = 0; i < 50; i++) begin
      logic [71:0] d;
      d = rand72();
      ipkt_data = d; ipkt_vld = 1'b1; go_frm = 1'b1; pkt_rdy = 1'b1;
      #1;
      chk("rw_busy", busy, 0);
      chk("rw_data", pkt_data, exp_q.pop_front());
      tick();
      exp_q.push_back(d);
      chk("rw_occ", occ, 8);
    end
    ipkt_vld = 1'b0; pkt_rdy = 1'b0;
    drain_all();

    // Flush at occ 5 with a write and a read offered.
    prep5();
    flush = 1'b1; ipkt_data = 72'h5A5A; ipkt_vld = 1'b1; pkt_rdy = 1'b1;
    tick();
    flush = 1'b0; ipkt_vld = 1'b0; pkt_rdy = 1'b0;
    exp_q.delete();
    chk("flush_occ", occ, 0);
    chk("flush_vld", pkt_vld, 0);
    chk("flush_ovf", ovf, 0);
    chk("flush_cfcf", cfcf, 1);

    wr8(72'h111); wr8(72'h222); wr8(72'h333);
    chk("postflush_occ", occ, 3);
    drain_all();

    // Reset mid-operation also clears the head data.
    prep5();
    rst_n = 1'b0; ipkt_data = 72'h7777; ipkt_vld = 1'b1; pkt_rdy = 1'b1;
    tick();
    rst_n = 1'b1; ipkt_vld = 1'b0; pkt_rdy = 1'b0;
    exp_q.delete();
    chk("midrst_occ", occ, 0);
    chk("midrst_vld", pkt_vld, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_cfcf", cfcf, 1);
    chk("midrst_data", pkt_data, 0);
    chk("midrst_busy", busy, 0);

    run_odd(1'b0, 5);
    run_odd(1'b1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
